vec_alu_arbiter: RTL

// Shares one vector_alu between NREQ requesters (scalar-issue, vector-issue, ...).

---
 rtl/vec_alu_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/vec_alu_arbiter.sv
// Round-robin arbiter sharing one vector ALU between NREQ requesters.
// Registers the granted operands, sequences alu_en for multi-cycle ops and tags results by id.
module vec_alu_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned MC_LAT  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][4:0]       req_op,
  input  logic [NREQ-1:0][7:0]       req_imm,
  input  logic [NREQ-1:0][3:0][31:0] req_v1,
  input  logic [NREQ-1:0][3:0][31:0] req_v2,
  input  logic [NREQ-1:0][31:0]      req_r1,
  input  logic [NREQ-1:0][31:0]      req_r2,
  output logic                       alu_en,
  output logic [4:0]                 alu_op,
  output logic [7:0]                 alu_imm,
  output logic [3:0][31:0]           alu_v1,
  output logic [3:0][31:0]           alu_v2,
  output logic [31:0]                alu_r1,
  output logic [31:0]                alu_r2,
  input  logic [3:0][31:0]           alu_vout,
  input  logic [31:0]                alu_rout,
  output logic [NREQ-1:0]            resp_valid,
  output logic [3:0][31:0]           resp_vout,
  output logic [31:0]                resp_rout,
  output logic                       busy
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(MC_LAT + 1);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e                        state_q, state_d;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic [IdxW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]               id_q;
  logic [ALU_LAT-1:0]            tag_vld_q;
  logic [ALU_LAT-1:0][IdxW-1:0]  tag_id_q;

  logic            grant_found;
  logic [IdxW-1:0] grant_idx;
  int              cand;
  logic            can_issue;
  logic            accept;
  logic            last_cycle;

  // Search order starts at rr_ptr and wraps modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      cand = (int'(rr_ptr_q) + k) % int'(NREQ);
      if (!grant_found && req_valid[IdxW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IdxW'(cand);
      end
    end
  end

  // cnt counts the alu_en cycles left in a HOLD op, including the current one.
  assign can_issue  = (state_q != StHold) || (cnt_q == CntW'(1));
  assign accept     = can_issue && grant_found;
  assign last_cycle = (state_q == StRun) || ((state_q == StHold) && (cnt_q == CntW'(1)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_ptr_d  = rr_ptr_q;
    req_ready = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
      rr_ptr_d = (grant_idx == IdxW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      if (req_op[grant_idx][4]) begin
        state_d = StHold;
        cnt_d   = CntW'(MC_LAT);
      end else begin
        state_d = StRun;
        cnt_d   = '0;
      end
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StRun:  state_d = StIdle;
        StHold: begin
          if (cnt_q == CntW'(1)) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      id_q     <= '0;
      alu_op   <= '0;
      alu_imm  <= '0;
      alu_v1   <= '0;
      alu_v2   <= '0;
      alu_r1   <= '0;
      alu_r2   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      if (accept) begin
        id_q    <= grant_idx;
        alu_op  <= req_op[grant_idx];
        alu_imm <= req_imm[grant_idx];
        alu_v1  <= req_v1[grant_idx];
        alu_v2  <= req_v2[grant_idx];
        alu_r1  <= req_r1[grant_idx];
        alu_r2  <= req_r2[grant_idx];
      end
    end
  end

  // Tag pushed on each op's final alu_en cycle, aligned with the ALU result latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      tag_vld_q[0] <= last_cycle;
      tag_id_q[0]  <= id_q;
      for (int i = 1; i < int'(ALU_LAT); i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  always_comb begin
    resp_valid = '0;
    if (tag_vld_q[ALU_LAT-1]) begin
      resp_valid[tag_id_q[ALU_LAT-1]] = 1'b1;
    end
  end

  assign alu_en    = (state_q != StIdle);
  assign resp_vout = (|resp_valid) ? alu_vout : '0;
  assign resp_rout = (|resp_valid) ? alu_rout : '0;
  assign busy      = (state_q != StIdle) || (|tag_vld_q);

endmodule
